dcache_miss_ctrl: RTL and testbench

//  Data-cache miss sequencer for the MEM stage. It produces the `hit` qualifier that gates the MEM/WB pipeline register.
//  On a miss it stalls the pipeline, writes back a dirty victim line, refills the line over a word-wide req/ack

---
 rtl/dcache_miss_ctrl.sv | 133 +++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer for the MEM stage: drives the hit qualifier, writes back a dirty victim, refills the line, updates the tag.
// Latency: hit is combinational (0 added cycles); a clean miss stalls LINE_WORDS acked beats + DONE + re-lookup; a dirty miss adds LINE_WORDS write beats.
// Backpressure: memReq is held high across beats until memAck; the beat only advances on ack, so no beat is ever dropped.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   memRead, memWrite, addr             MEM-stage access (held stable while hit=0)
//   tagHit, victimDirty, victimTag,     tag-array lookup results for addr's index
//   victimData                          cache word at {index, wbIdx}
//   hit                                 access complete, pipeline may advance
//   memReq, memWe, memAddr, memWdata,   word-wide memory bus (req/ack)
//   memAck, memRdata
//   wbIdx, fillWe, fillIdx, tagWe,      cache array write/read controls
//   lineIndex, missTag
//   missCount                           saturating count of misses taken
module dcache_miss_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = 6,
  localparam int BEAT_W    = $clog2(LINE_WORDS),
  localparam int OFF_W     = BEAT_W + 3,
  localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               tagHit,
  input  logic               victimDirty,
  input  logic [TAG_W-1:0]   victimTag,
  input  logic [DATA_W-1:0]  victimData,
  output logic               hit,
  output logic               memReq,
  output logic               memWe,
  output logic [ADDR_W-1:0]  memAddr,
  output logic [DATA_W-1:0]  memWdata,
  input  logic               memAck,
  input  logic [DATA_W-1:0]  memRdata,
  output logic [BEAT_W-1:0]  wbIdx,
  output logic               fillWe,
  output logic [BEAT_W-1:0]  fillIdx,
  output logic               tagWe,
  output logic [INDEX_W-1:0] lineIndex,
  output logic [TAG_W-1:0]   missTag,
  output logic [31:0]        missCount
);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t             state;
  logic [BEAT_W-1:0]  beat;
  logic [TAG_W-1:0]   missTagQ;
  logic [INDEX_W-1:0] lineIndexQ;
  logic [31:0]        missCnt;

  logic access;
  logic inWb;
  logic inFill;

  assign access = memRead | memWrite;
  assign inWb   = (state == WB);
  assign inFill = (state == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      missTagQ   <= '0;
      lineIndexQ <= '0;
      missCnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !tagHit) begin
            missTagQ   <= addr[ADDR_W-1 -: TAG_W];
            lineIndexQ <= addr[OFF_W +: INDEX_W];
            beat       <= '0;
            if (missCnt != 32'hFFFF_FFFF) missCnt <= missCnt + 32'd1;
            state      <= victimDirty ? WB : FILL;
          end
        end
        WB: begin
          if (memAck) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= FILL;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        FILL: begin
          if (memAck) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= DONE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // rst_n gates hit so the pipeline sees a stall for the whole reset window.
  assign hit      = rst_n & (state == IDLE) & (~access | tagHit);
  assign memReq   = inWb | inFill;
  assign memWe    = inWb;
  // Write-back targets the victim's tag; the refill targets the latched miss tag.
  assign memAddr  = inWb   ? {victimTag, lineIndexQ, beat, 3'b000} :
                    inFill ? {missTagQ,  lineIndexQ, beat, 3'b000} : '0;
  assign memWdata = inWb ? victimData : '0;
  assign wbIdx    = inWb ? beat : '0;
  // Read data is only written into the cache on an acked fill beat.
  assign fillWe   = inFill & memAck;
  assign fillIdx  = inFill ? beat : '0;
  assign tagWe    = (state == DONE);
  assign lineIndex = lineIndexQ;
  assign missTag   = missTagQ;
  assign missCount = missCnt;

  // memRdata passes straight to the cache data array; the controller only qualifies it.
  logic unusedRdata;
  assign unusedRdata = ^memRdata;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
module tb_dcache_miss_ctrl;

  localparam int TAG_W = 53;

  logic        clk;
  logic        rst_n;
  logic        memRead, memWrite;
  logic [63:0] addr;
  logic        tagHit, victimDirty;
  logic [TAG_W-1:0] victimTag;
  logic [63:0] victimData;
  logic        hit, memReq, memWe;
  logic [63:0] memAddr, memWdata;
  logic        memAck;
  logic [63:0] memRdata;
  logic [1:0]  wbIdx, fillIdx;
  logic        fillWe, tagWe;
  logic [5:0]  lineIndex;
  logic [TAG_W-1:0] missTag;
  logic [31:0] missCount;

  dcache_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite), .addr(addr),
    .tagHit(tagHit), .victimDirty(victimDirty), .victimTag(victimTag), .victimData(victimData),
    .hit(hit), .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata), .wbIdx(wbIdx), .fillWe(fillWe), .fillIdx(fillIdx),
    .tagWe(tagWe), .lineIndex(lineIndex), .missTag(missTag), .missCount(missCount)
  );

  // Cache read port model: word content is a function of the word index.
  assign victimData = 64'hDA7A_0000_0000_0000 | {62'd0, wbIdx};
  assign memRdata   = 64'hF111_0000_0000_0000 | {62'd0, fillIdx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tagWeCnt = 0;
  int fillWeCnt = 0;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  idx;
  } beat_t;
  beat_t expQ[$];

  // Bus monitor: every acked beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tagWe) tagWeCnt++;
      if (fillWe) fillWeCnt++;
      checks++;
      if (fillWe !== (memReq & memAck & ~memWe)) begin
        errors++;
        $display("FAIL fillWe_qual: fillWe=%0b required %0b", fillWe, memReq & memAck & ~memWe);
      end
      if (memReq && memAck) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: we=%0b addr=%h, required no beat", memWe, memAddr);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          if (memWe !== e.we || memAddr !== e.addr ||
              (e.we ? (memWdata !== e.wdata) : (fillIdx !== e.idx))) begin
            errors++;
            $display("FAIL beat: we=%0b addr=%h wdata=%h fillIdx=%0d, required we=%0b addr=%h wdata=%h fillIdx=%0d",
                     memWe, memAddr, memWdata, fillIdx, e.we, e.addr, e.wdata, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_beats(input logic [63:0] a, input logic dirty, input logic [TAG_W-1:0] vt, input int nFill);
    beat_t b;
    if (dirty) begin
      for (int i = 0; i < 4; i++) begin
        b.we = 1'b1;
        b.addr = ({11'd0, vt} << 11) | (a & 64'h7E0) | (64'(i) << 3);
        b.wdata = 64'hDA7A_0000_0000_0000 + 64'(i);
        b.idx = 2'(i);
        expQ.push_back(b);
      end
    end
    for (int i = 0; i < nFill; i++) begin
      b.we = 1'b0;
      b.addr = (a & ~64'h1F) | (64'(i) << 3);
      b.wdata = '0;
      b.idx = 2'(i);
      expQ.push_back(b);
    end
  endtask

  // Runs one miss to completion; call with time at #1 after a posedge.
  task automatic run_miss(input logic [63:0] a, input logic dirty, input logic [TAG_W-1:0] vt,
                          input int ackPer, input logic rd, input logic wr,
                          output int stall, output int gaps, output int tws, output int fills);
    int tw0, fw0, cyc;
    logic seen, done;
    tw0 = tagWeCnt; fw0 = fillWeCnt;
    push_beats(a, dirty, vt, 4);
    memRead = rd; memWrite = wr; addr = a; tagHit = 1'b0;
    victimDirty = dirty; victimTag = vt; memAck = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL miss_stall: hit=%0b required 0", hit);
    end
    stall = 0; gaps = 0; cyc = 0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      stall++; cyc++;
      tagHit = (tagWeCnt != tw0);
      memAck = ((cyc % ackPer) == 0);
      #1;
      if (hit) done = 1'b1;
      else if (memReq) seen = 1'b1;
      else if (seen && !tagWe) gaps++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL miss_timeout: hit=%0b after %0d cycles, required 1", hit, stall);
    end
    memRead = 1'b0; memWrite = 1'b0; memAck = 1'b0;
    tws = tagWeCnt - tw0;
    fills = fillWeCnt - fw0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memRead = 1'b1; memWrite = 1'b0; addr = 64'h1040; tagHit = 1'b1;
    victimDirty = 1'b0; victimTag = '0; memAck = 1'b0;
    #12;
    checks++;
    if (hit !== 1'b0 || memReq !== 1'b0 || tagWe !== 1'b0 || fillWe !== 1'b0 || memAddr !== 64'd0 ||
        missCount !== 32'd0 || lineIndex !== 6'd0 || missTag !== '0 || wbIdx !== 2'd0 || fillIdx !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: hit=%0b memReq=%0b tagWe=%0b fillWe=%0b memAddr=%h missCount=%0d, required all 0",
               hit, memReq, tagWe, fillWe, memAddr, missCount);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b1 || memReq !== 1'b0 || missCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_hit: hit=%0b memReq=%0b missCount=%0d, required 1 0 0", hit, memReq, missCount);
    end
    @(posedge clk); #1;
    checks++;
    if (hit !== 1'b1 || memReq !== 1'b0) begin
      errors++;
      $display("FAIL hit_hold: hit=%0b memReq=%0b, required 1 0", hit, memReq);
    end
    memRead = 1'b0;
  endtask

  task automatic test_clean_miss();
    int stall, gaps, tws, fills;
    @(posedge clk); #1;
    run_miss(64'h1040, 1'b0, '0, 1, 1'b1, 1'b0, stall, gaps, tws, fills);
    checks++;
    if (stall !== 6) begin errors++; $display("FAIL clean_stall: %0d cycles, required 6", stall); end
    checks++;
    if (fills !== 4) begin errors++; $display("FAIL clean_fillWe: %0d, required 4", fills); end
    checks++;
    if (tws !== 1) begin errors++; $display("FAIL clean_tagWe: %0d, required 1", tws); end
    checks++;
    if (missCount !== 32'd1 || lineIndex !== 6'd2 || missTag !== 53'd2) begin
      errors++;
      $display("FAIL clean_latch: missCount=%0d lineIndex=%0d missTag=%0d, required 1 2 2", missCount, lineIndex, missTag);
    end
    checks++;
    if (expQ.size() != 0 || gaps != 0) begin
      errors++;
      $display("FAIL clean_beats: %0d beats left, %0d req gaps, required 0 0", expQ.size(), gaps);
    end
  endtask

  task automatic test_dirty_miss();
    int stall, gaps, tws, fills;
    @(posedge clk); #1;
    run_miss(64'h2080, 1'b1, 53'h5, 3, 1'b1, 1'b1, stall, gaps, tws, fills);
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL dirty_beats: %0d beats left, required 0", expQ.size()); end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL dirty_req_gap: %0d gaps, required 0", gaps); end
    checks++;
    if (fills !== 4 || tws !== 1) begin
      errors++;
      $display("FAIL dirty_writes: fillWe=%0d tagWe=%0d, required 4 1", fills, tws);
    end
    checks++;
    if (missCount !== 32'd2) begin errors++; $display("FAIL dirty_count: %0d, required 2", missCount); end
    checks++;
    if (stall !== 26) begin errors++; $display("FAIL dirty_stall: %0d cycles, required 26", stall); end
  endtask

  task automatic test_reset_mid_fill();
    int tw0;
    @(posedge clk); #1;
    tw0 = tagWeCnt;
    push_beats(64'h3000, 1'b0, '0, 2);
    memRead = 1'b1; addr = 64'h3000; tagHit = 1'b0; victimDirty = 1'b0; memAck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; memRead = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0 || fillWe !== 1'b0 || tagWe !== 1'b0 || hit !== 1'b0 || missCount !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs: memReq=%0b fillWe=%0b tagWe=%0b hit=%0b missCount=%0d, required 0 0 0 0 0",
               memReq, fillWe, tagWe, hit, missCount);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (memReq !== 1'b0 || hit !== 1'b1 || tagWeCnt != tw0 || missCount !== 32'd0) begin
      errors++;
      $display("FAIL midreset_idle: memReq=%0b hit=%0b tagWe_pulses=%0d missCount=%0d, required 0 1 0 0",
               memReq, hit, tagWeCnt - tw0, missCount);
    end
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL midreset_beats: %0d beats left, required 0", expQ.size()); end
    memAck = 1'b0;
  endtask

  task automatic test_idle_ack();
    int fw0;
    fw0 = fillWeCnt;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0; memAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (memReq !== 1'b0 || hit !== 1'b1 || tagWe !== 1'b0) begin
        errors++;
        $display("FAIL idle_ack: memReq=%0b hit=%0b tagWe=%0b, required 0 1 0", memReq, hit, tagWe);
      end
    end
    checks++;
    if (fillWeCnt != fw0 || missCount !== 32'd0) begin
      errors++;
      $display("FAIL idle_ack_state: fillWe=%0d missCount=%0d, required 0 0", fillWeCnt - fw0, missCount);
    end
    memAck = 1'b0;
  endtask

  task automatic test_saturation();
    int stall, gaps, tws, fills;
    @(posedge clk); #1;
    force dut.missCnt = 32'hFFFF_FFFE;
    #1;
    release dut.missCnt;
    #1;
    checks++;
    if (missCount !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sat_preload: %h, required fffffffe", missCount);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      run_miss(64'h4000 + 64'(k) * 64'h800, 1'b0, '0, 1, 1'b0, 1'b1, stall, gaps, tws, fills);
      checks++;
      if (missCount !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL sat_count%0d: %h, required ffffffff", k, missCount);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_fill();
    test_idle_ack();
    test_saturation();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
